baccarat_deal_fsm: RTL and testbench

- Round sequencer for the Baccarat datapath.
- Drives the six card-register load strobes in dealing order and applies the third-card rules to the hand scores returned by the two hand-scoring blocks.
- Latches the win/tie lights at the end of each round.
- Sits between the top level and the player/dealer card registers; advances one step per slow_clock edge.

---
 rtl/baccarat_deal_fsm.sv | 146 ++++++++++++++
 tb/tb_baccarat_deal_fsm.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_deal_fsm.sv
// Baccarat round sequencer: card load strobes, third-card rules, win/tie lights.
// Optional win/tie tally counters are enabled by defining BACCARAT_TALLY_EN.
module baccarat_deal_fsm #(
  parameter int TALLY_W = 8
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       start,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       busy,
  output logic       round_done
`ifdef BACCARAT_TALLY_EN
  ,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_P1     = 4'd1,
    S_D1     = 4'd2,
    S_P2     = 4'd3,
    S_D2     = 4'd4,
    S_CHECK  = 4'd5,
    S_P3     = 4'd6,
    S_BANK   = 4'd7,
    S_D3     = 4'd8,
    S_RESULT = 4'd9,
    S_DONE   = 4'd10
  } state_t;

  state_t state;
  state_t state_nx;

  // Banker third-card table; a court card or ten (10-13) counts as zero.
  function automatic logic bank_draws(input logic [3:0] d, input logic [3:0] c);
    logic [3:0] v;
    logic       draw;
    v = (c <= 4'd9) ? c : 4'd0;
    case (d)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v == 4'd6) || (v == 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

  // Next-state decode.
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:   state_nx = start ? S_P1 : S_IDLE;
      S_P1:     state_nx = S_D1;
      S_D1:     state_nx = S_P2;
      S_P2:     state_nx = S_D2;
      S_D2:     state_nx = S_CHECK;
      S_CHECK: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
          state_nx = S_RESULT;
        end else if (pscore <= 4'd5) begin
          state_nx = S_P3;
        end else if (dscore <= 4'd5) begin
          state_nx = S_D3;
        end else begin
          state_nx = S_RESULT;
        end
      end
      S_P3:     state_nx = S_BANK;
      S_BANK:   state_nx = bank_draws(dscore, pcard3) ? S_D3 : S_RESULT;
      S_D3:     state_nx = S_RESULT;
      S_RESULT: state_nx = S_DONE;
      S_DONE:   state_nx = start ? S_P1 : S_DONE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register; outputs are registered from the next-state decode so they track state exactly.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state            <= S_IDLE;
      load_pcard1      <= 1'b0;
      load_pcard2      <= 1'b0;
      load_pcard3      <= 1'b0;
      load_dcard1      <= 1'b0;
      load_dcard2      <= 1'b0;
      load_dcard3      <= 1'b0;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      busy             <= 1'b0;
      round_done       <= 1'b0;
`ifdef BACCARAT_TALLY_EN
      player_wins      <= {TALLY_W{1'b0}};
      dealer_wins      <= {TALLY_W{1'b0}};
      ties             <= {TALLY_W{1'b0}};
`endif
    end else begin
      state       <= state_nx;
      load_pcard1 <= (state_nx == S_P1);
      load_pcard2 <= (state_nx == S_P2);
      load_pcard3 <= (state_nx == S_P3);
      load_dcard1 <= (state_nx == S_D1);
      load_dcard2 <= (state_nx == S_D2);
      load_dcard3 <= (state_nx == S_D3);
      busy        <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      round_done  <= (state == S_RESULT);
      // Lights are set leaving RESULT, held through DONE, and cleared anywhere else.
      if (state == S_RESULT) begin
        player_win_light <= (pscore >= dscore);
        dealer_win_light <= (dscore >= pscore);
      end else if (state_nx != S_DONE) begin
        player_win_light <= 1'b0;
        dealer_win_light <= 1'b0;
      end else begin
        player_win_light <= player_win_light;
        dealer_win_light <= dealer_win_light;
      end
`ifdef BACCARAT_TALLY_EN
      if (state == S_RESULT) begin
        if (pscore > dscore) begin
          if (player_wins != {TALLY_W{1'b1}}) player_wins <= player_wins + {{(TALLY_W-1){1'b0}}, 1'b1};
        end else if (dscore > pscore) begin
          if (dealer_wins != {TALLY_W{1'b1}}) dealer_wins <= dealer_wins + {{(TALLY_W-1){1'b0}}, 1'b1};
        end else begin
          if (ties != {TALLY_W{1'b1}}) ties <= ties + {{(TALLY_W-1){1'b0}}, 1'b1};
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_baccarat_deal_fsm.sv
// Directed bench for baccarat_deal_fsm; card registers and hand scoring are modelled here.
module tb_baccarat_deal_fsm;
  logic       slow_clock = 1'b0;
  logic       resetb;
  logic       start;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, busy, round_done;
`ifdef BACCARAT_TALLY_EN
  logic [7:0] player_wins, dealer_wins, ties;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  baccarat_deal_fsm #(.TALLY_W(8)) dut (
    .slow_clock(slow_clock), .resetb(resetb), .start(start),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
    .busy(busy), .round_done(round_done)
`ifdef BACCARAT_TALLY_EN
    , .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties)
`endif
  );

  always #5 slow_clock = ~slow_clock;

  // Cards to be dealt next, and the card registers they land in.
  logic [3:0] c_p1, c_d1, c_p2, c_d2, c_p3, c_d3;
  logic [3:0] r_p1, r_d1, r_p2, r_d2, r_p3, r_d3;

  function automatic int cv(input logic [3:0] c);
    return (c >= 4'd10) ? 0 : int'(c);
  endfunction

  function automatic logic [3:0] score3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    int s;
    s = (cv(a) + cv(b) + cv(c)) % 10;
    return s[3:0];
  endfunction

  always @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_p1 <= 4'd0; r_p2 <= 4'd0; r_p3 <= 4'd0;
      r_d1 <= 4'd0; r_d2 <= 4'd0; r_d3 <= 4'd0;
    end else begin
      if (load_pcard1) begin
        r_p1 <= c_p1; r_p2 <= 4'd0; r_p3 <= 4'd0;
        r_d1 <= 4'd0; r_d2 <= 4'd0; r_d3 <= 4'd0;
      end
      if (load_dcard1) r_d1 <= c_d1;
      if (load_pcard2) r_p2 <= c_p2;
      if (load_dcard2) r_d2 <= c_d2;
      if (load_pcard3) r_p3 <= c_p3;
      if (load_dcard3) r_d3 <= c_d3;
    end
  end

  assign pscore = score3(r_p1, r_p2, r_p3);
  assign dscore = score3(r_d1, r_d2, r_d3);
  assign pcard3 = r_p3;

  logic sp3, sd3, bad;
  int   p3c, d3c, len;

  // Plays one round; len is edges from the start edge to the round_done cycle, 0 on timeout.
  task automatic run_round(input logic [3:0] p1, d1, p2, d2, p3, d3, input logic hold_start);
    c_p1 = p1; c_d1 = d1; c_p2 = p2; c_d2 = d2; c_p3 = p3; c_d3 = d3;
    sp3 = 1'b0; sd3 = 1'b0; p3c = 0; d3c = 0; bad = 1'b0;
    start = 1'b1;
    @(posedge slow_clock); #1;
    if (!hold_start) start = 1'b0;
    len = 1;
    for (int i = 0; i < 20; i++) begin
      if ($countones({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3}) > 1) bad = 1'b1;
      if (busy !== 1'b1 || player_win_light !== 1'b0 || dealer_win_light !== 1'b0) bad = 1'b1;
      if (len == 1 && load_pcard1 !== 1'b1) bad = 1'b1;
      if (load_pcard3 === 1'b1) begin sp3 = 1'b1; p3c = len; end
      if (load_dcard3 === 1'b1) begin sd3 = 1'b1; d3c = len; end
      @(posedge slow_clock); #1;
      len++;
      if (round_done === 1'b1) break;
    end
    if (round_done !== 1'b1) len = 0;
  endtask

  task automatic test_reset;
    resetb = 1'b0; start = 1'b0;
    c_p1 = 4'd0; c_d1 = 4'd0; c_p2 = 4'd0; c_d2 = 4'd0; c_p3 = 4'd0; c_d3 = 4'd0;
    #12;
    n_cmp++;
    if ({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
         player_win_light, dealer_win_light, busy, round_done} !== 10'b0) begin
      n_bad++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    @(negedge slow_clock); resetb = 1'b1;
    repeat (3) @(posedge slow_clock); #1;
    n_cmp++;
    if (busy !== 1'b0 || load_pcard1 !== 1'b0) begin
      n_bad++; $display("FAIL idle_hold: busy=%0b load_pcard1=%0b, want 0 0", busy, load_pcard1);
    end
  endtask

  task automatic test_natural;
    run_round(4'd5, 4'd2, 4'd3, 4'd2, 4'd9, 4'd9, 1'b0);
    n_cmp++; if (len !== 7) begin n_bad++; $display("FAIL natural_len: got %0d want 7", len); end
    n_cmp++; if ({sp3, sd3} !== 2'b00) begin n_bad++; $display("FAIL natural_third: got %b want 00", {sp3, sd3}); end
    n_cmp++; if ({player_win_light, dealer_win_light} !== 2'b10) begin
      n_bad++; $display("FAIL natural_lights: got %b want 10", {player_win_light, dealer_win_light}); end
    n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL natural_seq: got bad=%0b want 0", bad); end
    @(posedge slow_clock); #1;
    n_cmp++; if (round_done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL done_pulse: round_done=%0b busy=%0b want 0 0", round_done, busy); end
    // Dealer natural 8 against player 4.
    run_round(4'd2, 4'd4, 4'd2, 4'd4, 4'd9, 4'd9, 1'b0);
    n_cmp++; if (len !== 7) begin n_bad++; $display("FAIL dnatural_len: got %0d want 7", len); end
    n_cmp++; if ({sp3, sd3, player_win_light, dealer_win_light} !== 4'b0001) begin
      n_bad++; $display("FAIL dnatural_res: got %b want 0001", {sp3, sd3, player_win_light, dealer_win_light}); end
  endtask

  task automatic test_player_draw;
    run_round(4'd2, 4'd3, 4'd3, 4'd4, 4'd8, 4'd9, 1'b0);
    n_cmp++; if ({sp3, sd3} !== 2'b10) begin n_bad++; $display("FAIL pdraw_third: got %b want 10", {sp3, sd3}); end
    n_cmp++; if (len === 0 || bad !== 1'b0) begin n_bad++; $display("FAIL pdraw_seq: len=%0d bad=%0b", len, bad); end
    n_cmp++; if ({player_win_light, dealer_win_light} !== 2'b01) begin
      n_bad++; $display("FAIL pdraw_lights: got %b want 01", {player_win_light, dealer_win_light}); end
    // Banker on 3 stands when the player's third card is an 8.
    run_round(4'd1, 4'd1, 4'd1, 4'd2, 4'd8, 4'd1, 1'b0);
    n_cmp++; if ({sp3, sd3, player_win_light, dealer_win_light} !== 4'b1001) begin
      n_bad++; $display("FAIL bank3_v8: got %b want 1001", {sp3, sd3, player_win_light, dealer_win_light}); end
  endtask

  task automatic test_banker_rule;
    run_round(4'd1, 4'd1, 4'd2, 4'd5, 4'd12, 4'd1, 1'b0);
    n_cmp++; if ({sp3, sd3, player_win_light, dealer_win_light} !== 4'b1001) begin
      n_bad++; $display("FAIL bank6_v0: got %b want 1001", {sp3, sd3, player_win_light, dealer_win_light}); end
    run_round(4'd1, 4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 1'b0);
    n_cmp++; if ({sp3, sd3} !== 2'b11) begin n_bad++; $display("FAIL bank6_v6_third: got %b want 11", {sp3, sd3}); end
    n_cmp++; if (d3c - p3c !== 2) begin n_bad++; $display("FAIL bank6_v6_timing: got %0d want 2", d3c - p3c); end
    n_cmp++; if ({player_win_light, dealer_win_light} !== 2'b10) begin
      n_bad++; $display("FAIL bank6_v6_lights: got %b want 10", {player_win_light, dealer_win_light}); end
  endtask

  task automatic test_banker_only_tie;
    run_round(4'd3, 4'd10, 4'd4, 4'd5, 4'd9, 4'd2, 1'b0);
    n_cmp++; if (len !== 8) begin n_bad++; $display("FAIL bonly_len: got %0d want 8", len); end
    n_cmp++; if ({sp3, sd3} !== 2'b01) begin n_bad++; $display("FAIL bonly_third: got %b want 01", {sp3, sd3}); end
    n_cmp++; if ({player_win_light, dealer_win_light} !== 2'b11) begin
      n_bad++; $display("FAIL tie_lights: got %b want 11", {player_win_light, dealer_win_light}); end
    repeat (3) @(posedge slow_clock); #1;
    n_cmp++; if ({player_win_light, dealer_win_light, round_done, busy} !== 4'b1100) begin
      n_bad++; $display("FAIL done_hold: got %b want 1100", {player_win_light, dealer_win_light, round_done, busy}); end
  endtask

  task automatic test_start_ignored;
    run_round(4'd5, 4'd2, 4'd3, 4'd2, 4'd9, 4'd9, 1'b1);
    n_cmp++; if (len !== 7 || player_win_light !== 1'b1) begin
      n_bad++; $display("FAIL held_start_round: len=%0d pw=%0b want 7 1", len, player_win_light); end
    @(posedge slow_clock); #1;
    start = 1'b0;
    n_cmp++; if ({player_win_light, dealer_win_light, busy, load_pcard1} !== 4'b0011) begin
      n_bad++; $display("FAIL restart_clear: got %b want 0011", {player_win_light, dealer_win_light, busy, load_pcard1}); end
    for (int i = 0; i < 20; i++) begin
      if (round_done === 1'b1) break;
      @(posedge slow_clock); #1;
    end
    n_cmp++; if (round_done !== 1'b1) begin n_bad++; $display("FAIL restart_done: got %0b want 1", round_done); end
  endtask

  task automatic test_reset_mid_round;
    c_p1 = 4'd5; c_d1 = 4'd2; c_p2 = 4'd3; c_d2 = 4'd2; c_p3 = 4'd9; c_d3 = 4'd9;
    start = 1'b1;
    @(posedge slow_clock); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (load_pcard2 === 1'b1) break;
      @(posedge slow_clock); #1;
    end
    n_cmp++; if (load_pcard2 !== 1'b1) begin n_bad++; $display("FAIL reach_p2: got %0b want 1", load_pcard2); end
    #2 resetb = 1'b0;
    #1;
    n_cmp++;
    if ({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
         player_win_light, dealer_win_light, busy, round_done} !== 10'b0) begin
      n_bad++; $display("FAIL async_abort: got nonzero outputs, want all 0");
    end
    @(posedge slow_clock); #1;
    @(negedge slow_clock); resetb = 1'b1;
    @(posedge slow_clock); #1;
    n_cmp++;
    if ({load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3, busy} !== 7'b0) begin
      n_bad++; $display("FAIL no_partial: got strobes/busy after abort, want 0");
    end
    run_round(4'd5, 4'd2, 4'd3, 4'd2, 4'd9, 4'd9, 1'b0);
    n_cmp++; if (len !== 7 || bad !== 1'b0 || player_win_light !== 1'b1) begin
      n_bad++; $display("FAIL post_abort_round: len=%0d bad=%0b pw=%0b want 7 0 1", len, bad, player_win_light); end
  endtask

`ifdef BACCARAT_TALLY_EN
  task automatic test_tally;
    @(negedge slow_clock); resetb = 1'b0;
    @(negedge slow_clock); resetb = 1'b1;
    run_round(4'd5, 4'd2, 4'd3, 4'd2, 4'd9, 4'd9, 1'b0);
    run_round(4'd2, 4'd4, 4'd2, 4'd4, 4'd9, 4'd9, 1'b0);
    run_round(4'd3, 4'd10, 4'd4, 4'd5, 4'd9, 4'd2, 1'b0);
    n_cmp++; if ({player_wins, dealer_wins, ties} !== {8'd1, 8'd1, 8'd1}) begin
      n_bad++; $display("FAIL tally_three: got %0d %0d %0d want 1 1 1", player_wins, dealer_wins, ties); end
    for (int i = 0; i < 255; i++) run_round(4'd5, 4'd2, 4'd3, 4'd2, 4'd9, 4'd9, 1'b0);
    n_cmp++; if ({player_wins, dealer_wins, ties} !== {8'd255, 8'd1, 8'd1}) begin
      n_bad++; $display("FAIL tally_sat: got %0d %0d %0d want 255 1 1", player_wins, dealer_wins, ties); end
  endtask
`endif

  initial begin
    test_reset;
    test_natural;
    test_player_draw;
    test_banker_rule;
    test_banker_only_tie;
    test_start_ignored;
    test_reset_mid_round;
`ifdef BACCARAT_TALLY_EN
    test_tally;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
